// File: rtl/vga_frame_reader.sv
// VGA scan-out: pixel-tick timing, raster read addresses into the
// frame-buffer BRAM, registered 12-bit RGB and active-low syncs.
//
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   rd_addr, rd_en        frame-buffer read request (one clk strobe)
//   rd_data               pixel word {R,G,B}, RD_LATENCY clk after rd_en
//   vga_r/g/b             colour outputs, 4 bits each
//   vga_hsync, vga_vsync  syncs, active low, aligned with rgb
//   frame_start           one-clk pulse on the pixel (0,0) tick
//   line_active           high while the current line is in V_ACTIVE
//   test_mode             colour-bar override (VGA_TEST_PATTERN_EN only)
//
// Build option: define VGA_TEST_PATTERN_EN to add test_mode colour bars.

module vga_frame_reader #(
  parameter int CLK_DIV    = 4,
  parameter int RD_LATENCY = 1,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [11:0]       rd_data,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              vga_hsync,
  output logic              vga_vsync,
  output logic              frame_start,
  output logic              line_active
`ifdef VGA_TEST_PATTERN_EN
  ,
  input  logic              test_mode
`endif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW    = $clog2(CLK_DIV);
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0]         div_cnt;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  logic [ADDR_W-1:0]     addr_cnt;
  logic [RD_LATENCY-1:0] lat_sr;
  logic [11:0]           pix_reg;
  logic [11:0]           rgb;
  logic                  vis_d;
  logic                  hs_d;
  logic                  vs_d;

  logic        pix_en;
  logic        visible;
  logic        h_last;
  logic        v_last;
  logic        hs_now;
  logic        vs_now;
  logic        rd_go;
  logic        cap_now;
  logic        tp_on;
  logic [11:0] pix_src;
  logic [11:0] rgb_src;

  assign {vga_r, vga_g, vga_b} = rgb;

  always_comb begin
    pix_en  = (div_cnt == DIV_LAST);
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    h_last  = (h_cnt == H_LAST);
    v_last  = (v_cnt == V_LAST);
    hs_now  = !((h_cnt >= HS_BEG) && (h_cnt <= HS_END));
    vs_now  = !((v_cnt >= VS_BEG) && (v_cnt <= VS_END));
    rd_go   = pix_en && visible && !tp_on;
    cap_now = lat_sr[RD_LATENCY-1];
    // Bypass lets RD_LATENCY reach CLK_DIV-1: the word lands on the
    // same edge the output stage consumes it.
    pix_src = cap_now ? rd_data : pix_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Raster address by increment only; cleared on the last frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
    end else if (pix_en) begin
      if (h_last && v_last) begin
        addr_cnt <= '0;
      end else if (visible) begin
        addr_cnt <= addr_cnt + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= rd_go;
      if (rd_go) begin
        rd_addr <= addr_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sr  <= '0;
      pix_reg <= '0;
    end else begin
      lat_sr[0] <= rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        lat_sr[i] <= lat_sr[i-1];
      end
      if (cap_now) begin
        pix_reg <= rd_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      line_active <= 1'b0;
    end else begin
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        line_active <= (v_cnt < V_VIS);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [11:0]   tp_d;

  assign tp_on = test_mode;

  // Bar counters track h_cnt so no divider is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
      tp_d    <= '0;
    end else if (pix_en) begin
      tp_d <= {{4{bar_idx[2]}}, {4{bar_idx[1]}}, {4{bar_idx[0]}}};
      if (h_last) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + BW'(1);
      end
    end
  end

  assign rgb_src = tp_on ? tp_d : pix_src;
`else
  assign tp_on   = 1'b0;
  assign rgb_src = pix_src;
`endif

  // Output stage: one tick behind the counters so rgb and syncs align.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d     <= 1'b0;
      hs_d      <= 1'b1;
      vs_d      <= 1'b1;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      rgb       <= '0;
    end else if (pix_en) begin
      vis_d     <= visible;
      hs_d      <= hs_now;
      vs_d      <= vs_now;
      vga_hsync <= hs_d;
      vga_vsync <= vs_d;
      rgb       <= vis_d ? rgb_src : 12'h000;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench for vga_frame_reader on a shrunken 16x9 raster
// (8x4 visible) with a latency-1 BRAM model returning addr[11:0].

module tb_vga_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = '0;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        frame_start;
  logic        line_active;

  int total = 0;
  int bad = 0;
  int pe = 0;
  int rd_cnt = 0;
  int seq_err = 0;
  int exp_a = 0;
  int s0 = 0;
  int s1 = 0;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .CLK_DIV   (4),
    .RD_LATENCY(1),
    .H_ACTIVE  (8),
    .H_FP      (2),
    .H_SYNC    (3),
    .H_BP      (3),
    .V_ACTIVE  (4),
    .V_FP      (1),
    .V_SYNC    (2),
    .V_BP      (2),
    .ADDR_W    (19)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hsync  (vga_hsync),
    .vga_vsync  (vga_vsync),
    .frame_start(frame_start),
    .line_active(line_active)
  );

  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[11:0];
  end

  always @(posedge clk) begin
    pe <= rst_n ? pe + 1 : 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a <= 0;
    end else if (rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_addr !== 19'(exp_a)) seq_err <= seq_err + 1;
      exp_a <= (exp_a == 31) ? 0 : exp_a + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the pix_en edge of pixel tick n.
  task automatic adv(input int n);
    do begin
      @(posedge clk);
      #1;
    end while (pe < 4 * (n + 1));
  endtask

  function automatic logic [31:0] rgb();
    return {20'd0, vga_r, vga_g, vga_b};
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rgb", rgb(), 0);
    chk("rst_hsync", vga_hsync, 1);
    chk("rst_vsync", vga_vsync, 1);
    chk("rst_fs", frame_start, 0);
    chk("rst_la", line_active, 0);

    @(negedge clk);
    rst_n = 1'b1;

    adv(0);
    chk("t0_fs", frame_start, 1);
    chk("t0_rd_en", rd_en, 1);
    chk("t0_addr", rd_addr, 0);
    chk("t0_la", line_active, 1);
    s0 = rd_cnt;
    @(posedge clk);
    #1;
    chk("t0_rd_en_1clk", rd_en, 0);
    chk("t0_fs_1clk", frame_start, 0);

    adv(5);
    chk("x5_addr", rd_addr, 5);
    chk("x5_rd_en", rd_en, 1);
    adv(6);
    chk("x5_rgb", rgb(), 32'h005);
    adv(8);
    chk("hblank_rd_en", rd_en, 0);
    chk("hblank_addr_hold", rd_addr, 7);
    chk("x7_rgb", rgb(), 32'h007);
    adv(9);
    chk("hblank_rgb", rgb(), 0);
    adv(10);
    chk("hs_before", vga_hsync, 1);
    adv(11);
    chk("hs_first", vga_hsync, 0);
    adv(13);
    chk("hs_last", vga_hsync, 0);
    adv(14);
    chk("hs_after", vga_hsync, 1);
    adv(17);
    chk("y1x0_rgb", rgb(), 32'h008);
    adv(27);
    chk("hs_line1", vga_hsync, 0);

    adv(55);
    chk("last_vis_addr", rd_addr, 31);
    chk("last_vis_rd_en", rd_en, 1);
    adv(56);
    chk("last_vis_rgb", rgb(), 32'h01F);
    adv(64);
    chk("vblank_rd_en", rd_en, 0);
    chk("vblank_la", line_active, 0);
    chk("vblank_addr_hold", rd_addr, 31);

    adv(80);
    chk("vs_before", vga_vsync, 1);
    adv(81);
    chk("vs_first", vga_vsync, 0);
    adv(112);
    chk("vs_last", vga_vsync, 0);
    adv(113);
    chk("vs_after", vga_vsync, 1);

    adv(143);
    chk("fs_not_early", frame_start, 0);
    adv(144);
    chk("f2_fs", frame_start, 1);
    chk("f2_addr", rd_addr, 0);
    chk("f2_rd_en", rd_en, 1);
    s1 = rd_cnt;
    chk("frame_reads", s1 - s0, 32);
    chk("addr_sequence", seq_err, 0);
    adv(150);
    chk("f2_x5_rgb", rgb(), 32'h005);

    adv(179);
    chk("pre_rst_addr", rd_addr, 19);
    chk("pre_rst_rgb", rgb(), 32'h012);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rd_addr", rd_addr, 0);
    chk("async_rd_en", rd_en, 0);
    chk("async_rgb", rgb(), 0);
    chk("async_la", line_active, 0);
    chk("async_hsync", vga_hsync, 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    adv(0);
    chk("rr_fs", frame_start, 1);
    chk("rr_addr", rd_addr, 0);
    chk("rr_rd_en", rd_en, 1);
    adv(143);
    chk("rr_fs_not_early", frame_start, 0);
    adv(144);
    chk("rr_fs_next", frame_start, 1);
    chk("rr_seq", seq_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
